// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_pkg
// Brief   : Shared AXI response codes and arbiter channel state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package axi_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [RESP_W-1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_response_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWNED = 2'b01,
    ERROR = 2'b10
  } arbiter_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_channel_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_channel_arbiter
// Brief   : One-channel ownership FSM, priority grant, DECERR/SLVERR responder
//           and optional response watchdog (enabled by ARBITER_TIMEOUT_EN).
// Revision: 1.0 - initial release
// ============================================================================
module axi_channel_arbiter
  import axi_pkg::*;
#(
  parameter int SLAVE_NUMBER   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W         = $clog2(SLAVE_NUMBER + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLAVE_NUMBER-1:0] match_i,
  input  logic [SLAVE_NUMBER-1:0] busy_i,
  input  logic                    addr_valid_i,
  input  logic                    resp_valid_i,
  input  logic                    resp_ready_i,
  output logic [SLAVE_NUMBER-1:0] bus_taken_o,
  output logic [SEL_W-1:0]        select_o,
  output logic                    err_valid_o,
  output logic [RESP_W-1:0]       err_resp_o,
  output logic                    err_ready_o,
  output logic                    timeout_o
);

  localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(SLAVE_NUMBER);

  arbiter_state_t          state_q, state_d;
  logic [SEL_W-1:0]        owner_q, owner_d;
  axi_response_t           err_resp_q, err_resp_d;

  logic [SLAVE_NUMBER-1:0] prio_taken;
  logic [SEL_W-1:0]        low_idx;
  logic                    any_match;
  logic                    handshake;
  logic                    timeout;

  // Busy is informational only; release is decided by the response handshake.
  logic unused_inputs;
  assign unused_inputs = (^busy_i) ^ (TIMEOUT_CYCLES > 1);

  always_comb begin : prio_enc
    prio_taken = '0;
    low_idx    = '0;
    any_match  = 1'b0;
    for (int i = 0; i < SLAVE_NUMBER; i++) begin
      prio_taken[i] = any_match;
      if (match_i[i] && !any_match) begin
        low_idx = SEL_W'(i);
      end
      any_match = any_match | match_i[i];
    end
  end

  assign handshake = resp_valid_i & resp_ready_i;

`ifdef ARBITER_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Counter holds the number of OWNED cycles already elapsed.
  always_comb begin
    count_d = '0;
    if (state_q == OWNED) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = (state_q == OWNED) && (count_q == CNT_LAST) && !handshake;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin : next_state
    state_d    = state_q;
    owner_d    = owner_q;
    err_resp_d = err_resp_q;
    case (state_q)
      IDLE: begin
        if (any_match) begin
          owner_d = low_idx;
          state_d = OWNED;
        end else if (addr_valid_i) begin
          err_resp_d = DECERR;
          state_d    = ERROR;
        end
      end
      OWNED: begin
        if (handshake) begin
          state_d = IDLE;
        end else if (timeout) begin
          err_resp_d = SLVERR;
          state_d    = ERROR;
        end
      end
      ERROR: begin
        if (resp_ready_i) begin
          err_resp_d = OKAY;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      err_resp_q <= OKAY;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      err_resp_q <= err_resp_d;
    end
  end

  always_comb begin : outputs
    bus_taken_o = prio_taken;
    select_o    = owner_q;
    err_valid_o = 1'b0;
    err_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        err_ready_o = addr_valid_i & ~any_match;
      end
      OWNED: begin
        for (int i = 0; i < SLAVE_NUMBER; i++) begin
          bus_taken_o[i] = (owner_q != SEL_W'(i));
        end
      end
      ERROR: begin
        bus_taken_o = '1;
        select_o    = ERR_SEL;
        err_valid_o = 1'b1;
      end
      default: begin
        bus_taken_o = '1;
      end
    endcase
  end

  assign err_resp_o = err_resp_q;
  assign timeout_o  = timeout;

endmodule
`default_nettype wire

// File: rtl/axi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : axi_bus_arbiter
// Brief   : Independent write/read ownership arbiters for the shared AXI bus.
//           Define ARBITER_TIMEOUT_EN to add the response watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module axi_bus_arbiter
  import axi_pkg::*;
#(
  parameter int SLAVE_NUMBER   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W         = $clog2(SLAVE_NUMBER + 1)
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESET,
  input  logic [SLAVE_NUMBER-1:0] write_match_i,
  input  logic [SLAVE_NUMBER-1:0] read_match_i,
  input  logic [SLAVE_NUMBER-1:0] write_busy_i,
  input  logic [SLAVE_NUMBER-1:0] read_busy_i,
  input  logic                    write_addr_valid_i,
  input  logic                    read_addr_valid_i,
  input  logic                    write_bvalid_i,
  input  logic                    write_bready_i,
  input  logic                    read_rvalid_i,
  input  logic                    read_rready_i,
  output logic [SLAVE_NUMBER-1:0] write_bus_taken_o,
  output logic [SLAVE_NUMBER-1:0] read_bus_taken_o,
  output logic [SEL_W-1:0]        write_select_o,
  output logic [SEL_W-1:0]        read_select_o,
  output logic                    write_err_bvalid_o,
  output logic                    read_err_rvalid_o,
  output logic [RESP_W-1:0]       write_err_bresp_o,
  output logic [RESP_W-1:0]       read_err_rresp_o,
  output logic                    write_err_ready_o,
  output logic                    read_err_ready_o,
  output logic                    write_timeout_o,
  output logic                    read_timeout_o
);

  axi_channel_arbiter #(
    .SLAVE_NUMBER   (SLAVE_NUMBER),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_write_arb (
    .clk          (axi_ACLK),
    .rst          (axi_ARESET),
    .match_i      (write_match_i),
    .busy_i       (write_busy_i),
    .addr_valid_i (write_addr_valid_i),
    .resp_valid_i (write_bvalid_i),
    .resp_ready_i (write_bready_i),
    .bus_taken_o  (write_bus_taken_o),
    .select_o     (write_select_o),
    .err_valid_o  (write_err_bvalid_o),
    .err_resp_o   (write_err_bresp_o),
    .err_ready_o  (write_err_ready_o),
    .timeout_o    (write_timeout_o)
  );

  axi_channel_arbiter #(
    .SLAVE_NUMBER   (SLAVE_NUMBER),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_arb (
    .clk          (axi_ACLK),
    .rst          (axi_ARESET),
    .match_i      (read_match_i),
    .busy_i       (read_busy_i),
    .addr_valid_i (read_addr_valid_i),
    .resp_valid_i (read_rvalid_i),
    .resp_ready_i (read_rready_i),
    .bus_taken_o  (read_bus_taken_o),
    .select_o     (read_select_o),
    .err_valid_o  (read_err_rvalid_o),
    .err_resp_o   (read_err_rresp_o),
    .err_ready_o  (read_err_ready_o),
    .timeout_o    (read_timeout_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_bus_arbiter
// Brief   : Self-checking bench: priority vector table plus multi-cycle
//           sequences; expectations queued per cycle and compared mid-cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_bus_arbiter;

  localparam int SN = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [SN-1:0] w_match, r_match, w_busy, r_busy;
  logic          w_av, r_av, bvalid, bready, rvalid, rready;
  logic [SN-1:0] w_taken, r_taken;
  logic [2:0]    w_sel, r_sel;
  logic          w_ebv, r_erv, w_erdy, r_erdy, w_tmo, r_tmo;
  logic [1:0]    w_eresp, r_eresp;

  always #5 clk = ~clk;

  axi_bus_arbiter #(
    .SLAVE_NUMBER   (SN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .axi_ACLK           (clk),
    .axi_ARESET         (rst),
    .write_match_i      (w_match),
    .read_match_i       (r_match),
    .write_busy_i       (w_busy),
    .read_busy_i        (r_busy),
    .write_addr_valid_i (w_av),
    .read_addr_valid_i  (r_av),
    .write_bvalid_i     (bvalid),
    .write_bready_i     (bready),
    .read_rvalid_i      (rvalid),
    .read_rready_i      (rready),
    .write_bus_taken_o  (w_taken),
    .read_bus_taken_o   (r_taken),
    .write_select_o     (w_sel),
    .read_select_o      (r_sel),
    .write_err_bvalid_o (w_ebv),
    .read_err_rvalid_o  (r_erv),
    .write_err_bresp_o  (w_eresp),
    .read_err_rresp_o   (r_eresp),
    .write_err_ready_o  (w_erdy),
    .read_err_ready_o   (r_erdy),
    .write_timeout_o    (w_tmo),
    .read_timeout_o     (r_tmo)
  );

  // sel / resp of -1 mean "not checked this cycle"
  typedef struct {
    string      name;
    bit         rd;
    logic [3:0] taken;
    int         sel;
    logic       ev;
    int         resp;
    logic       erdy;
    logic       tmo;
  } exp_t;

  typedef struct {
    logic [3:0] match;
    logic [3:0] taken_idle;
    int         owner;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_ch(input string name, input bit rd, input logic [3:0] taken,
                           input int sel, input logic ev, input int resp,
                           input logic erdy, input logic tmo);
    exp_t e;
    e.name = name; e.rd = rd; e.taken = taken; e.sel = sel;
    e.ev = ev; e.resp = resp; e.erdy = erdy; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input string name);
    expect_ch(name, 1'b0, 4'b0000, 0, 1'b0, 0, 1'b0, 1'b0);
    expect_ch(name, 1'b1, 4'b0000, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Compare everything queued for this cycle at the falling edge, then step.
  task automatic cycle();
    exp_t       e;
    logic [3:0] at;
    logic [2:0] as;
    logic [1:0] ar;
    logic       aev, ardy, ato;
    bit         ok;
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.rd) begin
        at = r_taken; as = r_sel; aev = r_erv; ar = r_eresp; ardy = r_erdy; ato = r_tmo;
      end else begin
        at = w_taken; as = w_sel; aev = w_ebv; ar = w_eresp; ardy = w_erdy; ato = w_tmo;
      end
      ok = (at === e.taken) && (aev === e.ev) && (ardy === e.erdy) && (ato === e.tmo);
      if (e.sel >= 0 && as !== 3'(e.sel)) ok = 1'b0;
      if (e.resp >= 0 && ar !== 2'(e.resp)) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s (%s): got taken=%b sel=%0d valid=%b resp=%b ready=%b tmo=%b; want taken=%b sel=%0d valid=%b resp=%0d ready=%b tmo=%b",
                 e.name, e.rd ? "rd" : "wr", at, as, aev, ar, ardy, ato,
                 e.taken, e.sel, e.ev, e.resp, e.erdy, e.tmo);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    w_match = '0; r_match = '0; w_busy = '0; r_busy = '0;
    w_av = 1'b0; r_av = 1'b0;
    bvalid = 1'b0; bready = 1'b0; rvalid = 1'b0; rready = 1'b0;
  endtask

  vec_t       vt[6];
  logic [3:0] owned;

  initial begin
    vt[0] = '{4'b0001, 4'b1110, 0};
    vt[1] = '{4'b0100, 4'b1000, 2};
    vt[2] = '{4'b0110, 4'b1100, 1};
    vt[3] = '{4'b1000, 4'b0000, 3};
    vt[4] = '{4'b1111, 4'b1110, 0};
    vt[5] = '{4'b1010, 4'b1100, 1};

    rst = 1'b1;
    quiet();
    @(posedge clk);
    #1;
    expect_reset("reset_state");
    cycle();
    rst = 1'b0;
    expect_reset("post_reset_idle");
    cycle();

    // Priority table on the write channel; read channel must stay quiet.
    for (int i = 0; i < 6; i++) begin
      w_match = vt[i].match; w_av = 1'b1;
      expect_ch("prio_idle", 1'b0, vt[i].taken_idle, -1, 1'b0, -1, 1'b0, 1'b0);
      expect_ch("rd_quiet", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
      cycle();
      owned = 4'b0001 << vt[i].owner;
      owned = ~owned;
      w_match = '0; w_av = 1'b0; w_busy = vt[i].match;
      bvalid = 1'b1; bready = 1'b1;
      expect_ch("prio_owned", 1'b0, owned, vt[i].owner, 1'b0, -1, 1'b0, 1'b0);
      cycle();
      quiet();
      expect_ch("prio_release", 1'b0, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
      cycle();
    end

    // Overlapping read windows: slave 1 wins.
    r_match = 4'b0110; r_av = 1'b1;
    expect_ch("overlap_idle", 1'b1, 4'b1100, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    r_match = '0; r_av = 1'b0; rvalid = 1'b1; rready = 1'b1;
    expect_ch("overlap_owned", 1'b1, 4'b1101, 1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    quiet();
    expect_ch("overlap_release", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();

    // Unmapped write: DECERR held while BREADY is low.
    w_av = 1'b1;
    expect_ch("decerr_accept", 1'b0, 4'b0000, -1, 1'b0, 0, 1'b1, 1'b0);
    cycle();
    w_av = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_ch("decerr_hold", 1'b0, 4'b1111, SN, 1'b1, 3, 1'b0, 1'b0);
      cycle();
    end
    bready = 1'b1;
    expect_ch("decerr_handshake", 1'b0, 4'b1111, SN, 1'b1, 3, 1'b0, 1'b0);
    cycle();
    bready = 1'b0;
    expect_ch("decerr_drop", 1'b0, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();

    // Back-to-back: match during handshake waits one IDLE cycle.
    w_match = 4'b0001; w_av = 1'b1;
    expect_ch("b2b_first_grant", 1'b0, 4'b1110, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    w_match = 4'b0100; bvalid = 1'b1; bready = 1'b1;
    expect_ch("b2b_no_grant_in_hs", 1'b0, 4'b1110, 0, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    bvalid = 1'b0; bready = 1'b0;
    expect_ch("b2b_second_grant", 1'b0, 4'b1000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    w_match = '0; w_av = 1'b0; bvalid = 1'b1; bready = 1'b1;
    expect_ch("b2b_second_owned", 1'b0, 4'b1011, 2, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    quiet();
    expect_ch("b2b_release", 1'b0, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();

    // Simultaneous write to slave 0 and read from slave 3.
    w_match = 4'b0001; w_av = 1'b1; r_match = 4'b1000; r_av = 1'b1;
    expect_ch("sim_wr_grant", 1'b0, 4'b1110, -1, 1'b0, -1, 1'b0, 1'b0);
    expect_ch("sim_rd_grant", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    quiet();
    bvalid = 1'b1; bready = 1'b1; rvalid = 1'b1; rready = 1'b1;
    expect_ch("sim_wr_owned", 1'b0, 4'b1110, 0, 1'b0, -1, 1'b0, 1'b0);
    expect_ch("sim_rd_owned", 1'b1, 4'b0111, 3, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    quiet();
    expect_ch("sim_wr_release", 1'b0, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    expect_ch("sim_rd_release", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();

    // Silent read slave: watchdog fires on OWNED cycle TO when enabled.
    r_match = 4'b0100; r_av = 1'b1;
    expect_ch("silent_grant", 1'b1, 4'b1000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    r_match = '0; r_av = 1'b0;
`ifdef ARBITER_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      expect_ch("silent_owned", 1'b1, 4'b1011, 2, 1'b0, -1, 1'b0, (k == TO));
      cycle();
    end
    expect_ch("timeout_slverr", 1'b1, 4'b1111, SN, 1'b1, 2, 1'b0, 1'b0);
    cycle();
    rready = 1'b1;
    expect_ch("timeout_handshake", 1'b1, 4'b1111, SN, 1'b1, 2, 1'b0, 1'b0);
    cycle();
    rready = 1'b0;
    expect_ch("timeout_release", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
`else
    for (int k = 1; k <= TO + 4; k++) begin
      expect_ch("silent_owned", 1'b1, 4'b1011, 2, 1'b0, -1, 1'b0, 1'b0);
      cycle();
    end
    rvalid = 1'b1; rready = 1'b1;
    expect_ch("late_handshake", 1'b1, 4'b1011, 2, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    quiet();
    expect_ch("late_release", 1'b1, 4'b0000, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
`endif

    // Reset mid-OWNED returns to reset values one cycle later.
    w_match = 4'b0010; w_av = 1'b1;
    expect_ch("rst_grant", 1'b0, 4'b1100, -1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    w_match = '0; w_av = 1'b0; rst = 1'b1;
    expect_ch("rst_still_owned", 1'b0, 4'b1101, 1, 1'b0, -1, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    expect_reset("rst_mid_owned");
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
